parity_seq_ctrl: RTL and testbench

Front-end controller for the serial parity checker.
- Arbitrates round-robin between two parallel-word requesters.
- Serialises the granted frame MSB-first into the checker: clears it, shifts FRAME_W bits with valid high, then samples parity_ok/counter.
- Returns a tagged result through a valid/ready response port.

---
 rtl/parity_seq_ctrl_pkg.sv | 18 +
 rtl/parity_seq_ctrl_if.sv | 27 ++
 rtl/parity_seq_ctrl_rr_arb2.sv | 46 ++++
 rtl/parity_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_parity_seq_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/parity_seq_ctrl_pkg.sv
// Shared types and constants for the parity checker front-end controller.
package parity_ctrl_pkg;

    localparam int FRAME_W_DEF = 8;
    localparam int CNT_W_DEF   = 4;

    localparam logic MODE_EVEN = 1'b0;
    localparam logic MODE_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        SHIFT  = 3'd2,
        SAMPLE = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/parity_seq_ctrl_if.sv
// Request and response handshake bundle between requesters/consumer and the controller.
interface parity_seq_ctrl_if
    import parity_ctrl_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF
);
    logic [1:0]         in_valid;
    logic [FRAME_W-1:0] in_data0;
    logic [FRAME_W-1:0] in_data1;
    logic [1:0]         in_mode;
    logic [1:0]         in_ready;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_id;
    logic               resp_ok;
    logic               resp_err;

    modport master (
        output in_valid, in_data0, in_data1, in_mode, resp_ready,
        input  in_ready, resp_valid, resp_id, resp_ok, resp_err
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_mode, resp_ready,
        output in_ready, resp_valid, resp_id, resp_ok, resp_err
    );
endinterface

// File: rtl/parity_seq_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational; the pointer
// moves to the requester that was not served when 'advance' is pulsed.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic       ptr_r;
    logic       served_r;
    logic [1:0] gnt_s;

    // Grant decode: a lone request wins, a tie goes to the pointer's requester.
    always_comb begin
        gnt_s = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = ptr_r ? 2'b10 : 2'b01;
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    assign gnt = gnt_s;

    // Remember who was granted, and hand priority to the other one on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r    <= 1'b0;
            served_r <= 1'b0;
        end else begin
            if (enable && (gnt_s != 2'b00)) begin
                served_r <= gnt_s[1];
            end
            if (advance) begin
                ptr_r <= ~served_r;
            end
        end
    end
endmodule

// File: rtl/parity_seq_ctrl.sv
// Front-end for the serial parity checker: arbitrates two requesters, shifts
// the granted frame MSB-first into the checker and returns a tagged result.
module parity_seq_ctrl
    import parity_ctrl_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    parity_seq_ctrl_if.slave bus,
    output logic             chk_clr,
    output logic             chk_valid,
    output logic             chk_data_in,
    output logic             chk_mode,
    input  logic             chk_parity_ok,
    input  logic [CNT_W-1:0] chk_counter,
    output logic             busy
);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_W - 1);

    state_t             state_r;
    state_t             next_state_s;
    logic [FRAME_W-1:0] shreg_r;
    logic [FRAME_W-1:0] shreg_nxt_s;
    logic [CNT_W-1:0]   bit_idx_r;
    logic               mode_r;
    logic               id_r;
    logic               idle_r;
    logic [1:0]         gnt_s;
    logic               accept_s;
    logic               handshake_s;
    logic               chk_clr_r;
    logic               chk_valid_r;
    logic               chk_data_r;
    logic               chk_mode_r;
    logic               busy_r;
    logic               resp_valid_r;
    logic               resp_ok_r;
    logic               resp_err_r;

    // idle_r is low during and right after reset so in_ready stays 0 while reset is asserted.
    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (reset),
        .req     (bus.in_valid),
        .enable  (idle_r),
        .advance (handshake_s),
        .gnt     (gnt_s)
    );

    assign bus.in_ready = gnt_s;
    assign accept_s     = idle_r & ((gnt_s & bus.in_valid) != 2'b00);
    assign handshake_s  = resp_valid_r & bus.resp_ready & (state_r == RESP);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode for the frame sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (accept_s)         next_state_s = CLR;    else next_state_s = IDLE;
            CLR:     next_state_s = SHIFT;
            SHIFT:   if (bit_idx_r == '0)  next_state_s = SAMPLE; else next_state_s = SHIFT;
            SAMPLE:  next_state_s = RESP;
            RESP:    if (handshake_s)      next_state_s = IDLE;   else next_state_s = RESP;
            default: next_state_s = IDLE;
        endcase
    end

    // Next shift-register contents: load on accept, shift left while serialising.
    always_comb begin
        shreg_nxt_s = shreg_r;
        if (accept_s) begin
            shreg_nxt_s = gnt_s[1] ? bus.in_data1 : bus.in_data0;
        end else if (state_r == SHIFT) begin
            shreg_nxt_s = shreg_r << 1;
        end else begin
            shreg_nxt_s = shreg_r;
        end
    end

    // Frame datapath: word, mode, requester tag, bit index and sampled result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_r    <= '0;
            bit_idx_r  <= '0;
            mode_r     <= MODE_EVEN;
            id_r       <= 1'b0;
            resp_ok_r  <= 1'b0;
            resp_err_r <= 1'b0;
        end else begin
            shreg_r <= shreg_nxt_s;
            if (accept_s) begin
                mode_r <= bus.in_mode[gnt_s[1]];
                id_r   <= gnt_s[1];
            end
            if (state_r == CLR) begin
                bit_idx_r <= LAST_IDX;
            end else if (state_r == SHIFT) begin
                bit_idx_r <= bit_idx_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (state_r == SAMPLE) begin
                resp_ok_r  <= chk_parity_ok;
                resp_err_r <= (chk_counter != FRAME_CNT);
            end
        end
    end

    // Registered outputs, decoded from the state being entered so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_r       <= 1'b0;
            busy_r       <= 1'b0;
            chk_clr_r    <= 1'b0;
            chk_valid_r  <= 1'b0;
            chk_data_r   <= 1'b0;
            chk_mode_r   <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            idle_r       <= (next_state_s == IDLE);
            busy_r       <= (next_state_s != IDLE);
            chk_clr_r    <= (next_state_s == CLR);
            chk_valid_r  <= (next_state_s == SHIFT);
            chk_data_r   <= (next_state_s == SHIFT) ? shreg_nxt_s[FRAME_W-1] : 1'b0;
            chk_mode_r   <= (next_state_s == SHIFT) ? mode_r : 1'b0;
            resp_valid_r <= (next_state_s == RESP);
        end
    end

    assign chk_clr        = chk_clr_r;
    assign chk_valid      = chk_valid_r;
    assign chk_data_in    = chk_data_r;
    assign chk_mode       = chk_mode_r;
    assign busy           = busy_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_id    = id_r;
    assign bus.resp_ok    = resp_ok_r;
    assign bus.resp_err   = resp_err_r;
endmodule

// File: tb/tb_parity_seq_ctrl.sv
// Directed, table-driven bench for parity_seq_ctrl with a behavioural checker model.
module tb_parity_seq_ctrl;
    import parity_ctrl_pkg::*;

    localparam int FW = 8;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    parity_seq_ctrl_if #(.FRAME_W(FW)) bus ();

    logic          chk_clr, chk_valid, chk_data_in, chk_mode, busy;
    logic          chk_parity_ok;
    logic [CW-1:0] chk_counter;

    parity_seq_ctrl #(.FRAME_W(FW), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .chk_clr       (chk_clr),
        .chk_valid     (chk_valid),
        .chk_data_in   (chk_data_in),
        .chk_mode      (chk_mode),
        .chk_parity_ok (chk_parity_ok),
        .chk_counter   (chk_counter),
        .busy          (busy)
    );

    // Serial parity checker model
    logic [CW-1:0] m_cnt  = '0;
    logic          m_par  = 1'b0;
    logic          m_mode = 1'b0;
    bit            cnt7_en = 1'b0;

    always @(posedge clk) begin
        if (chk_clr) begin
            m_cnt <= '0;
            m_par <= 1'b0;
        end else if (chk_valid) begin
            m_cnt  <= m_cnt + 4'd1;
            m_par  <= m_par ^ chk_data_in;
            m_mode <= chk_mode;
        end
    end

    assign chk_parity_ok = m_mode ? m_par : ~m_par;
    assign chk_counter   = cnt7_en ? 4'd7 : m_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] mode;
        bit         cnt7;
        int         stall;
        logic       exp_id;
        logic       exp_ok;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    logic [9:0] all_out_s;
    assign all_out_s = {bus.in_ready, chk_clr, chk_valid, chk_data_in, chk_mode,
                        bus.resp_valid, bus.resp_ok, bus.resp_err, busy};

    // Runs one frame from request to response handshake; starts and ends at a negedge.
    task automatic do_frame(input vec_t v);
        logic [1:0] exp_g;
        logic [7:0] dw;
        logic       md;
        bit         got;
        exp_g = v.exp_id ? 2'b10 : 2'b01;
        dw    = v.exp_id ? v.d1 : v.d0;
        md    = v.mode[v.exp_id];
        bus.in_valid = v.valid;
        bus.in_data0 = v.d0;
        bus.in_data1 = v.d1;
        bus.in_mode  = v.mode;
        cnt7_en      = v.cnt7;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.in_ready != 2'b00) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("grant", 16'(bus.in_ready), 16'(exp_g));
        if (!got) begin
            bus.in_valid = 2'b00;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        check("ready_pulse", 16'(bus.in_ready), 16'(2'b00));
        bus.in_valid = 2'b00;
        check("clr_cycle", 16'({chk_clr, chk_valid, chk_data_in, busy}), 16'(4'b1001));
        for (int b = 7; b >= 0; b--) begin
            @(negedge clk);
            check("shift_bit", 16'({chk_clr, chk_valid, chk_data_in, chk_mode}),
                  16'({1'b0, 1'b1, dw[b], md}));
        end
        @(negedge clk);
        check("sample_cycle", 16'({chk_valid, chk_data_in, bus.resp_valid, busy}), 16'(4'b0001));
        @(negedge clk);
        check("resp", 16'({bus.resp_valid, bus.resp_id, bus.resp_ok, bus.resp_err}),
              16'({1'b1, v.exp_id, v.exp_ok, v.exp_err}));
        bus.in_valid = v.valid;
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            check("stall_hold", 16'({bus.resp_valid, bus.resp_id, bus.resp_ok, bus.resp_err}),
                  16'({1'b1, v.exp_id, v.exp_ok, v.exp_err}));
            check("stall_ready", 16'(bus.in_ready), 16'(2'b00));
        end
        bus.in_valid   = 2'b00;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        cnt7_en        = 1'b0;
        check("resp_drop", 16'({bus.resp_valid, busy}), 16'(2'b00));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   stale;
        vec_t post;
        vecs[0] = '{2'b11, 8'hD1, 8'h07, 2'b00, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{2'b10, 8'hD1, 8'h07, 2'b00, 1'b0, 0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b11, 8'hD1, 8'h07, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 8'hD1, 8'h07, 2'b10, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{2'b01, 8'hFF, 8'h07, 2'b00, 1'b0, 5, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{2'b10, 8'hFF, 8'h80, 2'b00, 1'b1, 0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{2'b01, 8'h00, 8'h80, 2'b01, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{2'b01, 8'hD1, 8'h80, 2'b00, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        post    = '{2'b11, 8'hB4, 8'h80, 2'b00, 1'b0, 0, 1'b0, 1'b1, 1'b0};

        bus.in_valid   = 2'b11;
        bus.in_data0   = 8'hD1;
        bus.in_data1   = 8'h07;
        bus.in_mode    = 2'b00;
        bus.resp_ready = 1'b1;
        #12;
        check("reset_outputs", 16'(all_out_s), 16'(10'd0));
        @(negedge clk);
        @(negedge clk);
        bus.in_valid   = 2'b00;
        bus.resp_ready = 1'b0;
        reset          = 1'b1;

        for (int k = 0; k < 8; k++) begin
            do_frame(vecs[k]);
        end

        // Reset during the cycle presenting bit 4 of a frame
        bus.in_valid = 2'b01;
        bus.in_data0 = 8'hB5;
        bus.in_mode  = 2'b00;
        #1;
        check("mid_grant", 16'(bus.in_ready), 16'(2'b01));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 2'b00;
        for (int b = 7; b >= 4; b--) begin
            @(negedge clk);
        end
        check("mid_bit4", 16'({chk_valid, chk_data_in}), 16'(2'b11));
        bus.in_valid = 2'b11;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 16'(all_out_s), 16'(10'd0));
        @(negedge clk);
        @(negedge clk);
        check("reset_hold", 16'(all_out_s), 16'(10'd0));
        bus.in_valid = 2'b00;
        reset = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.resp_valid || busy) stale = 1'b1;
        end
        check("no_stale_resp", 16'(stale), 16'(1'b0));
        do_frame(post);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
